des_round_engine: RTL and testbench
===================================

Name: des_round_engine

Overview:
- Iterative DES datapath that sits directly downstream of the key-schedule block and consumes its 16 48-bit round subkeys.
- Accepts one 64-bit block over a valid/ready handshake and applies IP, then ROUNDS Feistel rounds at one round per clock, then the final swap and FP.
- Returns the result on a valid/ready output.
- Drives a subkey index to the key schedule and reads the selected subkey back combinationally in the same cycle.

Parameters:
- ROUNDS, 16, number of Feistel rounds (1..16). Values below 16 are for debug/reduced-round test only.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input block valid
- in_ready  out  1  engine can accept a block
- in_block  in  64  plaintext/ciphertext; DES bit 1 = in_block[63]
- in_decrypt  in  1  sampled on accept; 1 = decrypt (reverse subkey order)
- subkey_idx  out  4  subkey requested this cycle; value n selects K(n+1)
- subkey  in  48  subkey for subkey_idx, same cycle; DES bit 1 = subkey[47]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_block  out  64  result; DES bit 1 = out_block[63]
- busy  out  1  high in ROUND or DONE

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high. rst has priority over every other event.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_block=0, subkey_idx=0, round counter=0, L/R=0, decrypt flag=0.
- States and transitions:
  - IDLE: in_ready=1. When in_valid&&in_ready (cycle T): register {L,R}=IP(in_block), latch in_decrypt, clear the counter, go to ROUND.
  - ROUND: on each cycle r=0..ROUNDS-1:
    - subkey_idx = decrypt ? ROUNDS-1-r : r
    - L<=R, R<=L^f(R,subkey)
    - after r=ROUNDS-1, register out_block=FP({R,L}) (swapped) and go to DONE.
  - DONE: out_valid=1, with out_block held stable until out_valid&&out_ready, then go to IDLE. out_valid drops the following cycle.
- Latency: accept at T → out_valid at T+ROUNDS+1 (T+17 by default).
- Throughput: in_ready=0 in ROUND and DONE. A new accept is possible at earliest one cycle after the output handshake.
- Backpressure: out_ready held low keeps out_valid=1 and out_block unchanged indefinitely.
- in_valid while busy is ignored; no state change and no data is captured.
- subkey_idx is 0 in IDLE and DONE.
- rst during ROUND or DONE:
  - the block in flight is discarded with no output;
  - in_ready=1 in the cycle after reset deasserts.
- f function: E expansion 32→48, XOR with subkey, S1..S8 (6→4, row = outer bits, column = inner bits), then P permutation.
- All tables use standard FIPS 46-3 numbering, where bit 1 is the MSB.

Optional Feature:
- Macro: DES_SUBKEY_REG_EN.
- Defined:
  - subkey is captured into a 48-bit register before use;
  - subkey_idx runs one cycle ahead, with the first index issued in the accept cycle;
  - throughput stays one round per clock;
  - latency becomes T+ROUNDS+2;
  - DONE, backpressure and reset behaviour are unchanged.
- Undefined: combinational subkey use as above; no extra register.

Decomposition:
- Shared package des_pkg containing:
  - state enum typedef (IDLE, ROUND, DONE) and DES_ROUNDS=16;
  - IP, FP, E and P tables, and S-box constants as functions, shared with the key-schedule block;
  - 48-bit subkey and 64-bit block typedefs.
- One sub-module, des_f_function: purely combinational (E, XOR, S-boxes, P), 32-bit R plus 48-bit subkey in, 32-bit out.
  - Instantiated once.
  - Reusable by an unrolled variant later.

Test Plan:
- Encrypt FIPS vector:
  - stimulus: key 133457799BBCDFF1 via the key-schedule model; in_block 0123456789ABCDEF, in_decrypt=0.
  - response: out_block 85E813540F0AB405 at T+17; subkey_idx sequence 0..15; subkey at idx 0 = 1B02EFFC7072.
- Decrypt:
  - stimulus: same key; in_block 85E813540F0AB405, in_decrypt=1.
  - response: out_block 0123456789ABCDEF; subkey_idx sequence 15..0.
- Second vector:
  - stimulus: key 0E329232EA6D0D73; in_block 8787878787878787.
  - response: out_block 0000000000000000.
- Backpressure and busy:
  - stimulus: out_ready=0 for 10 cycles after out_valid; in_valid held high with another block throughout.
  - response: out_valid and out_block stable; in_ready=0; second block accepted only in the cycle after the output handshake.
- Reset mid-operation:
  - stimulus: rst pulsed at round 7.
  - response: no out_valid; in_ready=1 the next cycle; a fresh encrypt of 0123456789ABCDEF still yields 85E813540F0AB405.
- DES_SUBKEY_REG_EN build:
  - stimulus: rerun vectors 1 and 2.
  - response: identical results at T+18; subkey_idx leads the round counter by one cycle.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES constants: the IP/FP/E/P permutation tables, the S-boxes and the
// block/subkey types used by the round engine and the key-schedule block.
package des_pkg;

   localparam int DES_ROUNDS = 16;

   typedef enum logic [1:0] {IDLE, ROUND, DONE} des_state_e;
   typedef logic [63:0] block_t;
   typedef logic [47:0] subkey_t;

   // Table entries are FIPS 46-3 bit numbers, bit 1 being the MSB of the vector.
   localparam int IP_T [64] = '{
      58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

   localparam int FP_T [64] = '{
      40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
      38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
      36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
      34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

   localparam int E_T [48] = '{
      32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

   localparam int P_T [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

   localparam int SBOX_T [8][64] = '{
      '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
         0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
        15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
      '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
         3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
        13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
      '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
         1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
      '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
        13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
         3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
      '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
        14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
        11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
      '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
        10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
         4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
      '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
        13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
         6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
      '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
         1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
         2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

   function automatic block_t ip(input block_t b);
      block_t o;
      for (int i = 0; i < 64; i++) o[63-i] = b[64-IP_T[i]];
      return o;
   endfunction

   function automatic block_t fp(input block_t b);
      block_t o;
      for (int i = 0; i < 64; i++) o[63-i] = b[64-FP_T[i]];
      return o;
   endfunction

   function automatic logic [47:0] e_expand(input logic [31:0] r);
      logic [47:0] o;
      for (int i = 0; i < 48; i++) o[47-i] = r[32-E_T[i]];
      return o;
   endfunction

   function automatic logic [31:0] p_perm(input logic [31:0] x);
      logic [31:0] o;
      for (int i = 0; i < 32; i++) o[31-i] = x[32-P_T[i]];
      return o;
   endfunction

   // Row comes from the outer bits (1 and 6), column from the inner four.
   function automatic logic [3:0] sbox(input int n, input logic [5:0] x);
      return 4'(SBOX_T[n][{x[5], x[0], x[4:1]}]);
   endfunction

endpackage

// File: rtl/des_round_engine_if.sv
// Block/result handshake and subkey lookup bus of the DES round engine.
interface des_round_engine_if;
   import des_pkg::*;

   // Both streams transfer on a cycle where valid && ready; valid never waits
   // for ready and, once raised, holds with stable data until the transfer.
   logic       in_valid;
   logic       in_ready;
   block_t     in_block;
   logic       in_decrypt;
   logic [3:0] subkey_idx;
   subkey_t    subkey;
   logic       out_valid;
   logic       out_ready;
   block_t     out_block;
   logic       busy;

   modport slave (
      input  in_valid, in_block, in_decrypt, subkey, out_ready,
      output in_ready, subkey_idx, out_valid, out_block, busy
   );

   modport master (
      output in_valid, in_block, in_decrypt, subkey, out_ready,
      input  in_ready, subkey_idx, out_valid, out_block, busy
   );
endinterface

// File: rtl/des_f_function.sv
// DES Feistel f function: E expansion, subkey XOR, S1..S8 and P. Purely combinational.
module des_f_function
   import des_pkg::*;
(
   input  logic [31:0] r,
   input  subkey_t     k,
   output logic [31:0] f
);
   logic [47:0] x;
   logic [31:0] s;

   always_comb begin
      x = e_expand(r) ^ k;
      s = '0;
      for (int j = 0; j < 8; j++) s[31-4*j -: 4] = sbox(j, x[47-6*j -: 6]);
      f = p_perm(s);
   end
endmodule

// File: rtl/des_round_engine.sv
// Iterative DES datapath, one Feistel round per clock. Defining DES_SUBKEY_REG_EN
// registers the incoming subkey and issues subkey_idx one cycle ahead.
module des_round_engine
   import des_pkg::*;
#(
   parameter int ROUNDS = DES_ROUNDS
)(
   input  logic                clk,
   input  logic                rst,
   des_round_engine_if.slave   bus,
   output des_state_e          fsm_state
);
`ifdef DES_SUBKEY_REG_EN
   // One extra step after the last round applies FP to the registered L/R.
   localparam int STEPS = ROUNDS + 1;
`else
   localparam int STEPS = ROUNDS;
`endif

   des_state_e  state_q, state_d;
   logic [4:0]  cnt_q;
   logic [31:0] l_q, r_q, f_out;
   logic        dec_q;
   block_t      out_q;
   subkey_t     round_key;
   logic        accept, last_step, do_round;
   logic [3:0]  idx;

   function automatic logic [3:0] key_index(input logic dec, input logic [4:0] step);
      return dec ? 4'(ROUNDS - 1 - int'(step)) : step[3:0];
   endfunction

   assign accept    = bus.in_valid && (state_q == IDLE);
   assign last_step = (cnt_q == 5'(STEPS - 1));
   assign do_round  = (state_q == ROUND) && (cnt_q < 5'(ROUNDS));

`ifdef DES_SUBKEY_REG_EN
   subkey_t key_q;
   always_ff @(posedge clk) begin
      if (rst) key_q <= '0;
      else     key_q <= bus.subkey;
   end
   assign round_key = key_q;
`else
   assign round_key = bus.subkey;
`endif

   des_f_function u_f (.r(r_q), .k(round_key), .f(f_out));

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)        state_d = ROUND;
         ROUND:   if (last_step)     state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state_q == IDLE);
      bus.out_valid = (state_q == DONE);
      bus.busy      = (state_q != IDLE);
      bus.out_block = out_q;
      idx           = 4'd0;
`ifdef DES_SUBKEY_REG_EN
      if (accept)
         idx = key_index(bus.in_decrypt, 5'd0);
      else if (state_q == ROUND && cnt_q < 5'(ROUNDS - 1))
         idx = key_index(dec_q, cnt_q + 5'd1);
`else
      if (state_q == ROUND) idx = key_index(dec_q, cnt_q);
`endif
      bus.subkey_idx = idx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         l_q   <= '0;
         r_q   <= '0;
         dec_q <= 1'b0;
         cnt_q <= '0;
         out_q <= '0;
      end else if (accept) begin
         {l_q, r_q} <= ip(bus.in_block);
         dec_q      <= bus.in_decrypt;
         cnt_q      <= '0;
      end else if (state_q == ROUND) begin
         cnt_q <= cnt_q + 5'd1;
         if (do_round) begin
            l_q <= r_q;
            r_q <= l_q ^ f_out;
         end
`ifdef DES_SUBKEY_REG_EN
         if (last_step) out_q <= fp({r_q, l_q});
`else
         // Final swap folded in: {R16, L16} with R16 computed this cycle.
         if (last_step) out_q <= fp({l_q ^ f_out, r_q});
`endif
      end
   end

   assign fsm_state = state_q;
endmodule

// File: tb/tb_des_round_engine.sv
// Directed bench for des_round_engine with a reference DES key-schedule model
// feeding subkeys; expected blocks are known FIPS vectors.
module tb_des_round_engine;
   import des_pkg::*;

`ifdef DES_SUBKEY_REG_EN
   localparam int LAT = DES_ROUNDS + 2;
`else
   localparam int LAT = DES_ROUNDS + 1;
`endif

   localparam int PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

   localparam int PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

   localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   des_round_engine_if bus();
   des_state_e fsm_state;

   des_round_engine #(.ROUNDS(DES_ROUNDS)) dut (
      .clk(clk), .rst(rst), .bus(bus), .fsm_state(fsm_state)
   );

   logic [47:0] ks [16];
   logic [47:0] sk_first;
   logic [63:0] exp_q [$];
   int n_total = 0;
   int n_bad   = 0;

   assign bus.subkey = ks[bus.subkey_idx];

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic gen_keys(input logic [63:0] key);
      logic [55:0] cd;
      logic [27:0] c, d;
      for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
      c = cd[55:28];
      d = cd[27:0];
      for (int r = 0; r < 16; r++) begin
         for (int s = 0; s < SHIFT_T[r]; s++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
         end
         cd = {c, d};
         for (int i = 0; i < 48; i++) ks[r][47-i] = cd[56-PC2_T[i]];
      end
   endtask

   task automatic send(input logic [63:0] blk, input logic dec);
      int w;
      w = 0;
      @(negedge clk);
      while (!bus.in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (w >= 50) check_val("send_ready_timeout", 64'd0, 64'd1);
      bus.in_valid   = 1'b1;
      bus.in_block   = blk;
      bus.in_decrypt = dec;
`ifdef DES_SUBKEY_REG_EN
      #1;
      sk_first = bus.subkey;
      check_val("early_idx", 64'(bus.subkey_idx), dec ? 64'd15 : 64'd0);
`endif
   endtask

   // Returns on the negedge where out_valid is first seen.
   task automatic wait_result(input logic dec, input logic hold, input logic [63:0] next_blk);
      logic [63:0] seq_obs, seq_exp, expv;
      logic [1:0]  rb_k1;
      logic [3:0]  e;
      int          k, step;
      bit          seen, vld;
      seen = 0; seq_obs = '0; seq_exp = '0; rb_k1 = '0;
      for (k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (!hold) bus.in_valid = 1'b0;
         if (k == 1) begin
            rb_k1 = {bus.in_ready, bus.busy};
`ifndef DES_SUBKEY_REG_EN
            sk_first = bus.subkey;
`endif
            if (hold) begin
               bus.in_block   = next_blk;
               bus.in_decrypt = 1'b1;
            end
         end
         if (k <= 16) seq_obs[64-4*k +: 4] = bus.subkey_idx;
         if (bus.out_valid) begin
            seen = 1;
            break;
         end
      end
      for (int i = 1; i <= 16; i++) begin
`ifdef DES_SUBKEY_REG_EN
         step = i; vld = (i < 16);
`else
         step = i - 1; vld = 1;
`endif
         e = vld ? (dec ? 4'(15 - step) : 4'(step)) : 4'd0;
         seq_exp[64-4*i +: 4] = e;
      end
      if (seen) check_val("latency", 64'(k), 64'(LAT));
      else      check_val("out_timeout", 64'd0, 64'd1);
      check_val("idx_seq", seq_obs, seq_exp);
      check_val("ready_busy_round", 64'(rb_k1), 64'b01);
      if (exp_q.size() == 0) check_val("exp_q_empty", 64'd0, 64'd1);
      else begin
         expv = exp_q.pop_front();
         check_val("out_block", bus.out_block, expv);
      end
   endtask

   task automatic finish_out();
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check_val("out_valid_drop", 64'(bus.out_valid), 64'd0);
      check_val("in_ready_after", 64'(bus.in_ready), 64'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      logic seen_ov;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_block = '0; bus.in_decrypt = 1'b0; bus.out_ready = 1'b0;
      gen_keys(64'h133457799BBCDFF1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_val("rst_in_ready",  64'(bus.in_ready), 64'd1);
      check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check_val("rst_busy",      64'(bus.busy), 64'd0);
      check_val("rst_out_block", bus.out_block, 64'd0);
      check_val("rst_idx",       64'(bus.subkey_idx), 64'd0);
      check_val("rst_state",     64'(fsm_state), 64'(IDLE));
      check_val("ks_model_k1",   64'(ks[0]), 64'h1B02EFFC7072);

      // FIPS encrypt vector
      exp_q.push_back(64'h85E813540F0AB405);
      send(64'h0123456789ABCDEF, 1'b0);
      wait_result(1'b0, 1'b0, 64'd0);
      check_val("subkey_k1", 64'(sk_first), 64'h1B02EFFC7072);
      finish_out();

      // decrypt back
      exp_q.push_back(64'h0123456789ABCDEF);
      send(64'h85E813540F0AB405, 1'b1);
      wait_result(1'b1, 1'b0, 64'd0);
      finish_out();

      // backpressure with a second block pending throughout
      exp_q.push_back(64'h85E813540F0AB405);
      send(64'h0123456789ABCDEF, 1'b0);
      wait_result(1'b0, 1'b1, 64'h85E813540F0AB405);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_val("bp_out_valid", 64'(bus.out_valid), 64'd1);
         check_val("bp_out_block", bus.out_block, 64'h85E813540F0AB405);
         check_val("bp_in_ready",  64'(bus.in_ready), 64'd0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check_val("bp_drop_valid", 64'(bus.out_valid), 64'd0);
      check_val("bp_ready_now",  64'(bus.in_ready), 64'd1);
      exp_q.push_back(64'h0123456789ABCDEF);
      wait_result(1'b1, 1'b0, 64'd0);
      finish_out();

      // reset during round 7
      send(64'h0123456789ABCDEF, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (7) @(negedge clk);
      check_val("mid_busy", 64'(bus.busy), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_val("mr_in_ready",  64'(bus.in_ready), 64'd1);
      check_val("mr_busy",      64'(bus.busy), 64'd0);
      check_val("mr_out_block", bus.out_block, 64'd0);
      check_val("mr_idx",       64'(bus.subkey_idx), 64'd0);
      seen_ov = 1'b0;
      repeat (20) begin
         @(negedge clk);
         seen_ov = seen_ov | bus.out_valid;
      end
      check_val("mr_no_output", 64'(seen_ov), 64'd0);
      exp_q.push_back(64'h85E813540F0AB405);
      send(64'h0123456789ABCDEF, 1'b0);
      wait_result(1'b0, 1'b0, 64'd0);
      finish_out();

      // second key
      gen_keys(64'h0E329232EA6D0D73);
      exp_q.push_back(64'h0000000000000000);
      send(64'h8787878787878787, 1'b0);
      wait_result(1'b0, 1'b0, 64'd0);
      finish_out();
      exp_q.push_back(64'h8787878787878787);
      send(64'h0000000000000000, 1'b1);
      wait_result(1'b1, 1'b0, 64'd0);
      finish_out();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
